imem_boot_loader: RTL and testbench

Writes a program into instruction memory from a byte stream received after reset, and holds the processor's fetch stage until the image is complete. It sits between a byte-oriented receiver (UART RX or debug port) and the write port of instruction memory. It drives the memory write strobe, the word-aligned byte address and the data word. It is the writer counterpart to the fetch path, which only reads instruction memory.

---
 rtl/imem_boot_loader.sv | 204 ++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed byte stream after reset and
// writes it word by word into instruction memory, holding the CPU fetch stage
// until the whole image has been written.
//
// Frame: LEN_HI, LEN_LO (word count N, big-endian), then 4*N data bytes,
// each word MSB first.
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN
//   When defined, one trailing checksum byte (XOR of LEN_HI, LEN_LO and all
//   data bytes) is required before Done. A mismatch ends in the error state.
//
// Handshake: RxValid is a one-cycle strobe qualifying RxData. There is no
// ready; every strobed byte is consumed in the cycle it is presented.
// MemWE is a one-cycle write pulse; MemWA/MemWD are valid while it is high.
//
// DbgState exposes the FSM state encoding for observation.

module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        MemWE,
  output logic [31:0] MemWA,
  output logic [31:0] MemWD,
  output logic        CpuHold,
  output logic        Done,
  output logic        Err,
  output logic [2:0]  DbgState
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
`ifdef IMEM_LOAD_CHECKSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t          r_state;
  logic [7:0]      r_len_hi;
  logic [15:0]     r_len;
  logic [ADDR_W:0] r_word_idx;
  logic [1:0]      r_lane;
  logic [31:0]     r_asm;
  logic            r_mem_we;
  logic [31:0]     r_mem_wa;
  logic [31:0]     r_mem_wd;
  logic            r_cpu_hold;
  logic            r_done;
  logic            r_err;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]      r_csum;
  logic [7:0]      w_csum_nxt;
`endif

  state_t          w_state_nxt;
  state_t          w_fin_state;
  logic [7:0]      w_len_hi_nxt;
  logic [15:0]     w_len_nxt;
  logic [15:0]     w_len_rx;
  logic [ADDR_W:0] w_idx_nxt;
  logic [1:0]      w_lane_nxt;
  logic [31:0]     w_asm_nxt;
  logic [31:0]     w_word;
  logic            w_last_word;
  logic            w_wr;
  logic [31:0]     w_wa_nxt;
  logic [31:0]     w_wd_nxt;
  logic            w_done_nxt;
  logic            w_err_nxt;

  // Next-state, datapath and registered-output decode; advances only on RxValid.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_hi_nxt = r_len_hi;
    w_len_nxt    = r_len;
    w_idx_nxt    = r_word_idx;
    w_lane_nxt   = r_lane;
    w_asm_nxt    = r_asm;
    w_wr         = 1'b0;
    w_wa_nxt     = r_mem_wa;
    w_wd_nxt     = r_mem_wd;
    w_len_rx     = {r_len_hi, RxData};
    w_word       = {r_asm[23:0], RxData};
    w_last_word  = ((32'(r_word_idx) + 32'd1) == 32'(r_len));
`ifdef IMEM_LOAD_CHECKSUM_EN
    w_fin_state  = S_CSUM;
    w_csum_nxt   = r_csum;
`else
    w_fin_state  = S_DONE;
`endif

    if (RxValid) begin
      case (r_state)
        S_LEN_HI: begin
          w_len_hi_nxt = RxData;
          w_state_nxt  = S_LEN_LO;
`ifdef IMEM_LOAD_CHECKSUM_EN
          w_csum_nxt   = RxData;
`endif
        end
        S_LEN_LO: begin
          w_len_nxt = w_len_rx;
`ifdef IMEM_LOAD_CHECKSUM_EN
          w_csum_nxt = r_csum ^ RxData;
`endif
          if (w_len_rx == 16'd0) begin
            w_state_nxt = w_fin_state;
          end else if (32'(w_len_rx) > MAX_WORDS) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_asm_nxt  = w_word;
          w_lane_nxt = r_lane + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
          w_csum_nxt = r_csum ^ RxData;
`endif
          if (r_lane == 2'd3) begin
            w_wr      = 1'b1;
            w_wa_nxt  = 32'(r_word_idx) << 2;
            w_wd_nxt  = w_word;
            w_idx_nxt = r_word_idx + (ADDR_W + 1)'(1);
            if (w_last_word) begin
              w_state_nxt = w_fin_state;
            end
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CSUM: begin
          if (RxData == r_csum) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
`endif
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end

    // Done trails the final write pulse by one cycle; with no write in the
    // same cycle (N=0, checksum byte) it follows the transition directly.
    w_done_nxt = (r_state == S_DONE) || ((w_state_nxt == S_DONE) && !w_wr);
    w_err_nxt  = (w_state_nxt == S_ERR);
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_LEN_HI;
      r_len_hi   <= 8'd0;
      r_len      <= 16'd0;
      r_word_idx <= '0;
      r_lane     <= 2'd0;
      r_asm      <= 32'd0;
      r_mem_we   <= 1'b0;
      r_mem_wa   <= 32'd0;
      r_mem_wd   <= 32'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_len_hi   <= w_len_hi_nxt;
      r_len      <= w_len_nxt;
      r_word_idx <= w_idx_nxt;
      r_lane     <= w_lane_nxt;
      r_asm      <= w_asm_nxt;
      r_mem_we   <= w_wr;
      r_mem_wa   <= w_wa_nxt;
      r_mem_wd   <= w_wd_nxt;
      r_cpu_hold <= !w_done_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

  assign MemWE    = r_mem_we;
  assign MemWA    = r_mem_wa;
  assign MemWD    = r_mem_wd;
  assign CpuHold  = r_cpu_hold;
  assign Done     = r_done;
  assign Err      = r_err;
  assign DbgState = r_state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader (ADDR_W=4, MAX_WORDS=16).
// Table of frames plus hand-written timing/reset sequences; memory writes
// are checked against an expected queue filled from a small frame model.

module tb_imem_boot_loader;

  localparam int ADDR_W    = 4;
  localparam int MAX_WORDS = 16;
  localparam int NV        = 7;
  localparam int NB        = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .RxData   (rx_data),
    .RxValid  (rx_valid),
    .MemWE    (mem_we),
    .MemWA    (mem_wa),
    .MemWD    (mem_wd),
    .CpuHold  (cpu_hold),
    .Done     (done),
    .Err      (err),
    .DbgState (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          cyc = 0;
  int          we_count = 0;
  int          we_cyc[8];
  logic        we_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every MemWE pulse must match the head of the expected queue
  // and must not be the continuation of a previous pulse.
  always @(negedge clk) begin
    logic [63:0] exp_w;
    if (mem_we) begin
      checks++;
      if (we_prev) begin
        errors++;
        $display("FAIL we_width actual=MemWE high 2+ cycles required=1 cycle (addr=%h)", mem_wa);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%h@%h required=no write", mem_wd, mem_wa);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_wa, mem_wd} !== exp_w)
          begin
            errors++;
            $display("FAIL write actual=%h@%h required=%h@%h",
                     mem_wd, mem_wa, exp_w[31:0], exp_w[63:32]);
          end
      end
      if (we_count < 8) we_cyc[we_count] = cyc;
      we_count++;
    end
    we_prev = mem_we;
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    int   n;
    int   gap;
    logic exp_done;
    logic exp_err;
  } vec_t;

  vec_t       vecs[NV];
  logic [7:0] vb[NV][NB];

  task automatic new_vec(input int v, input int gap, input logic d, input logic e);
    vecs[v].n        = 0;
    vecs[v].gap      = gap;
    vecs[v].exp_done = d;
    vecs[v].exp_err  = e;
  endtask

  task automatic add(input int v, input logic [7:0] x);
    vb[v][vecs[v].n] = x;
    vecs[v].n = vecs[v].n + 1;
  endtask

  function automatic logic [7:0] xor_all(input int v);
    logic [7:0] x = 8'd0;
    for (int k = 0; k < vecs[v].n; k++) x ^= vb[v][k];
    return x;
  endfunction

  // Frame model: pushes the writes a correct loader performs for vector v.
  task automatic model_writes(input int v);
    int nw;
    nw = int'({vb[v][0], vb[v][1]});
    if (nw > MAX_WORDS) return;
    for (int w = 0; w < nw; w++) begin
      if (2 + 4 * w + 3 < vecs[v].n)
        exp_q.push_back({32'(w * 4), vb[v][2+4*w], vb[v][3+4*w], vb[v][4+4*w], vb[v][5+4*w]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d) actual=%h required=%h", name, tag, act, exp);
    end
  endtask

  // Called at a negedge; presents one byte for one cycle, then idles gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Reset with a stray strobe held high; outputs must sit at reset values.
  task automatic do_reset(input int tag);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset_outputs", tag, {26'd0, mem_we, cpu_hold, done, err, 2'b00},
          {26'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
    check("reset_addr_data", tag, mem_wa | mem_wd, 32'd0);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;

    // v0: N=2 back-to-back
    new_vec(0, 0, 1'b1, 1'b0);
    add(0, 8'h00); add(0, 8'h02);
    add(0, 8'hDE); add(0, 8'hAD); add(0, 8'hBE); add(0, 8'hEF);
    add(0, 8'h01); add(0, 8'h23); add(0, 8'h45); add(0, 8'h67);
    // v1: same frame, 3 idle cycles between bytes
    new_vec(1, 3, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) add(1, vb[0][k]);
    // v2: N=17 exceeds MAX_WORDS; following bytes ignored
    new_vec(2, 1, 1'b0, 1'b1);
    add(2, 8'h00); add(2, 8'h11);
    add(2, 8'hDE); add(2, 8'hAD); add(2, 8'hBE); add(2, 8'hEF);
    // v3: empty image
    new_vec(3, 0, 1'b1, 1'b0);
    add(3, 8'h00); add(3, 8'h00);
    // v4: truncated frame, stays holding
    new_vec(4, 0, 1'b0, 1'b0);
    add(4, 8'h00); add(4, 8'h01); add(4, 8'hAA); add(4, 8'hBB);
    // v5: N=3 random data, random spacing
    new_vec(5, $urandom_range(0, 2), 1'b1, 1'b0);
    add(5, 8'h00); add(5, 8'h03);
    for (int k = 0; k < 12; k++) add(5, 8'($urandom_range(0, 255)));
    // v6: N=1 AA BB CC DD
`ifdef IMEM_LOAD_CHECKSUM_EN
    new_vec(6, 0, 1'b0, 1'b1);
`else
    new_vec(6, 0, 1'b1, 1'b0);
`endif
    add(6, 8'h00); add(6, 8'h01);
    add(6, 8'hAA); add(6, 8'hBB); add(6, 8'hCC); add(6, 8'hDD);
`ifdef IMEM_LOAD_CHECKSUM_EN
    add(0, xor_all(0));
    add(1, xor_all(1));
    add(3, xor_all(3));
    add(5, xor_all(5));
    add(6, 8'h02);
`endif

    // ---- table loop ----
    for (int v = 0; v < NV; v++) begin
      do_reset(v);
      exp_q.delete();
      we_count = 0;
      model_writes(v);
      for (int k = 0; k < vecs[v].n; k++) send_byte(vb[v][k], vecs[v].gap);
      repeat (3) @(negedge clk);
      check("done", v, 32'(done), 32'(vecs[v].exp_done));
      check("err", v, 32'(err), 32'(vecs[v].exp_err));
      check("cpu_hold", v, 32'(cpu_hold), 32'(!vecs[v].exp_done));
      check("writes_left", v, exp_q.size(), 0);
      exp_q.delete();
    end

    // ---- H1: back-to-back timing of write pulses and Done ----
    do_reset(100);
    we_count = 0;
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    exp_q.push_back({32'h4, 32'h01234567});
    for (int k = 0; k < 10; k++) send_byte(vb[0][k], 0);
    check("h1_we_last", 100, 32'(mem_we), 32'd1);
    check("h1_done_early", 100, 32'(done), 32'd0);
    @(negedge clk);
    check("h1_we_spacing", 100, we_cyc[1] - we_cyc[0], 4);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("h1_done_before_csum", 100, 32'(done), 32'd0);
    check("h1_hold_before_csum", 100, 32'(cpu_hold), 32'd1);
    send_byte(8'h20, 0);
`endif
    check("h1_done", 100, 32'(done), 32'd1);
    check("h1_hold", 100, 32'(cpu_hold), 32'd0);
    check("h1_writes_left", 100, exp_q.size(), 0);
    // bytes after Done are ignored
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    for (int k = 0; k < 4; k++) send_byte(8'h5A, 0);
    repeat (2) @(negedge clk);
    check("h1_ignored_after_done", 100, {30'd0, done, err}, {30'd0, 2'b10});

    // ---- H2: N=0 Done latency ----
    do_reset(101);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("h2_done_wait_csum", 101, 32'(done), 32'd0);
    send_byte(8'h00, 0);
    check("h2_done_csum_ok", 101, 32'(done), 32'd1);
    do_reset(102);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h5A, 0);
    check("h2_err_csum_bad", 102, {30'd0, err, cpu_hold}, {30'd0, 2'b11});
    check("h2_done_csum_bad", 102, 32'(done), 32'd0);
`else
    check("h2_done_n0", 101, 32'(done), 32'd1);
    check("h2_hold_n0", 101, 32'(cpu_hold), 32'd0);
`endif

    // ---- H3: oversize length, Err latency and ignored data ----
    do_reset(103);
    we_count = 0;
    send_byte(8'h00, 0); send_byte(8'h11, 0);
    check("h3_err", 103, 32'(err), 32'd1);
    check("h3_hold", 103, 32'(cpu_hold), 32'd1);
    for (int k = 0; k < 8; k++) send_byte(8'($urandom_range(0, 255)), 0);
    repeat (2) @(negedge clk);
    check("h3_no_writes", 103, we_count, 0);
    check("h3_sticky", 103, {30'd0, err, done}, {30'd0, 2'b10});

    // ---- H4: reset in the middle of a frame ----
    do_reset(104);
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    for (int k = 0; k < 8; k++) send_byte(vb[0][k], 0);
    do_reset(104);
    check("h4_first_word", 104, exp_q.size(), 0);
    exp_q.delete();
    exp_q.push_back({32'h0, 32'h11223344});
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(8'h45, 0);
`endif
    repeat (2) @(negedge clk);
    check("h4_done", 104, {30'd0, done, err}, {30'd0, 2'b10});
    check("h4_writes_left", 104, exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
